// File: rtl/csr_defs.sv
`default_nettype none
// ============================================================================
// Module      : csr_defs (package)
// Description : Shared CSR numbers, field positions, exception codes, timer
//               state encoding and the masked-write helper used by the timer
//               and interrupt controller.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package csr_defs;

    // CSR numbers owned by the timer / interrupt controller
    localparam logic [13:0] CSR_ECFG  = 14'h004;
    localparam logic [13:0] CSR_ESTAT = 14'h005;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    // Field bit positions
    localparam int TCFG_EN     = 0;
    localparam int TCFG_PERIOD = 1;
    localparam int IS_TI       = 11;
    localparam int IS_IPI      = 12;
    localparam int IS_HWI_LO   = 2;
    localparam int IS_W        = 13;

    // LIE bit 10 has no interrupt source behind it and always reads 0
    localparam logic [IS_W-1:0] LIE_WMASK = 13'h1BFF;

    // Exception codes
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;

    // Timer state encoding
    typedef enum logic [0:0] {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

    // Bitwise masked update: masked bits take the write data, others hold
    function automatic logic [31:0] mask_merge(
        input logic [31:0] old_val,
        input logic [31:0] wmask,
        input logic [31:0] wvalue
    );
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_timer_intc_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_intc_if
// Description : CSR write/read bus between the writeback stage / CSR file
//               (master) and the timer-interrupt controller (slave).
// Signals     : csr_num/csr_we/csr_wmask/csr_wvalue - write port
//               csr_rnum -> csr_rhit/csr_rvalue      - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_timer_intc_if;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [13:0] csr_rnum;
    logic        csr_rhit;
    logic [31:0] csr_rvalue;

    modport master (
        output csr_num, csr_we, csr_wmask, csr_wvalue, csr_rnum,
        input  csr_rhit, csr_rvalue
    );

    modport slave (
        input  csr_num, csr_we, csr_wmask, csr_wvalue, csr_rnum,
        output csr_rhit, csr_rvalue
    );
endinterface
`default_nettype wire

// File: rtl/csr_timer_intc_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Multi-flop synchronizer for asynchronous level inputs.
// Ports       : clk, resetn (async active-low), d [WIDTH] in, q [WIDTH] out
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    // Stage 0 is the metastability-exposed flop; stage DEPTH-1 feeds q
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[DEPTH-2:0], d};
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/csr_timer_intc.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_intc
// Description : Stable timer (TCFG/TVAL/TICLR) and interrupt controller
//               (ECFG.LIE, ESTAT.IS) sharing the CSR write port with WB.
//               Drives a registered interrupt request to the decode stage.
// Ports       : clk, resetn        - clock, async active-low reset
//               csr (slave)        - CSR write / combinational read bus
//               crmd_ie            - global interrupt enable
//               hwi[7:0]           - asynchronous hardware interrupt lines
//               ipi                - inter-processor interrupt (sync level)
//               has_int            - registered interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_intc
    import csr_defs::*;
#(
    parameter int TIMER_W     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    csr_timer_intc_if.slave   csr,
    input  wire logic         crmd_ie,
    input  wire logic [7:0]   hwi,
    input  wire logic         ipi,
    output logic              has_int
);

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic w_we_ecfg;
    logic w_we_estat;
    logic w_we_tcfg;
    logic w_ticlr_hit;

    assign w_we_ecfg   = csr.csr_we && (csr.csr_num == CSR_ECFG);
    assign w_we_estat  = csr.csr_we && (csr.csr_num == CSR_ESTAT);
    assign w_we_tcfg   = csr.csr_we && (csr.csr_num == CSR_TCFG);
    assign w_ticlr_hit = csr.csr_we && (csr.csr_num == CSR_TICLR)
                         && csr.csr_wvalue[0] && csr.csr_wmask[0];

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic [TIMER_W-1:0] r_tcfg;
    logic [TIMER_W-1:0] r_tval;
    tmr_state_t         r_state;

    logic [31:0]        w_tcfg_merged;
    logic [TIMER_W-1:0] w_tcfg_new;
    logic [TIMER_W-1:0] w_reload_new;
    logic [TIMER_W-1:0] w_reload;
    logic               w_expire;

    assign w_tcfg_merged = mask_merge(32'(r_tcfg), csr.csr_wmask, csr.csr_wvalue);
    assign w_tcfg_new    = w_tcfg_merged[TIMER_W-1:0];
    assign w_reload_new  = {w_tcfg_new[TIMER_W-1:2], 2'b00};
    assign w_reload      = {r_tcfg[TIMER_W-1:2], 2'b00};

    // Expiry is the cycle spent at zero while running; TI sets on the
    // following edge regardless of any concurrent TCFG write.
    assign w_expire = (r_state == TMR_RUN) && (r_tval == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tcfg  <= '0;
            r_tval  <= '0;
            r_state <= TMR_IDLE;
        end else if (w_we_tcfg) begin
            // A software write overrides decrement, reload and stop
            r_tcfg <= w_tcfg_new;
            if (w_tcfg_new[TCFG_EN]) begin
                r_tval  <= w_reload_new;
                r_state <= TMR_RUN;
            end else begin
                r_state <= TMR_IDLE;
            end
        end else if (r_state == TMR_RUN) begin
            if (r_tval != '0) begin
                r_tval <= r_tval - TIMER_W'(1);
            end else if (r_tcfg[TCFG_PERIOD]) begin
                r_tval <= w_reload;
            end else begin
                r_tcfg[TCFG_EN] <= 1'b0;
                r_state         <= TMR_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt status sources
    // ------------------------------------------------------------------
    logic            r_ti;
    logic            r_ipi;
    logic [1:0]      r_sw_is;
    logic [IS_W-1:0] r_lie;
    logic [7:0]      w_hwi_sync;
    logic [IS_W-1:0] w_is;
    logic [1:0]      w_sw_is_new;
    logic [IS_W-1:0] w_lie_new;

    sync_ff #(
        .WIDTH (8),
        .DEPTH (SYNC_STAGES)
    ) u_hwi_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (hwi),
        .q      (w_hwi_sync)
    );

    assign w_sw_is_new = (r_sw_is & ~csr.csr_wmask[1:0])
                       | (csr.csr_wvalue[1:0] & csr.csr_wmask[1:0]);
    assign w_lie_new   = ((r_lie & ~csr.csr_wmask[IS_W-1:0])
                       | (csr.csr_wvalue[IS_W-1:0] & csr.csr_wmask[IS_W-1:0]))
                       & LIE_WMASK;

    // IS layout: [12]=IPI [11]=TI [10]=0 [9:2]=HWI [1:0]=SWI
    assign w_is = {r_ipi, r_ti, 1'b0, w_hwi_sync, r_sw_is};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ti    <= 1'b0;
            r_ipi   <= 1'b0;
            r_sw_is <= '0;
            r_lie   <= '0;
            has_int <= 1'b0;
        end else begin
            // Set has priority over a coincident TICLR clear
            if (w_expire) begin
                r_ti <= 1'b1;
            end else if (w_ticlr_hit) begin
                r_ti <= 1'b0;
            end
            r_ipi <= ipi;
            if (w_we_estat) begin
                r_sw_is <= w_sw_is_new;
            end
            if (w_we_ecfg) begin
                r_lie <= w_lie_new;
            end
            has_int <= crmd_ie & (|(w_is & r_lie));
        end
    end

    // ------------------------------------------------------------------
    // Combinational read port (returns pre-write values)
    // ------------------------------------------------------------------
    always_comb begin
        csr.csr_rhit   = 1'b0;
        csr.csr_rvalue = '0;
        case (csr.csr_rnum)
            CSR_ECFG: begin
                csr.csr_rhit   = 1'b1;
                csr.csr_rvalue = 32'(r_lie);
            end
            CSR_ESTAT: begin
                csr.csr_rhit   = 1'b1;
                csr.csr_rvalue = 32'(w_is);
            end
            CSR_TCFG: begin
                csr.csr_rhit   = 1'b1;
                csr.csr_rvalue = 32'(r_tcfg);
            end
            CSR_TVAL: begin
                csr.csr_rhit   = 1'b1;
                csr.csr_rvalue = 32'(r_tval);
            end
            CSR_TICLR: begin
                csr.csr_rhit   = 1'b1;
            end
            default: begin
                csr.csr_rhit   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
